// File: rtl/mem_port_ctrl.sv
// -----------------------------------------------------------------------------
// mem_port_ctrl
//
// Bridges a valid/ready request stream onto a single fixed-latency memory port
// and returns read data, in request order, through a small response FIFO.
// Writes are fire-and-forget. Reads are tracked by a READ_LATENCY-deep valid
// shift register. When a read's bit leaves the register, the memory data is
// pushed into the FIFO on that edge. Read credit is counted as queued
// responses plus reads still in flight, so the FIFO can never overflow.
//
// Optional feature: define MEM_PORT_BOUNDS_CHECK_EN to enable an address range
// check. A request at or above ADDR_LIMIT is still accepted, but it never
// reaches the memory port. It sets the sticky err flag. If it is a read, it
// returns 32'hDEAD_BEEF in order. Without the macro, every address goes
// through and err is tied to 0.
//
// Ports
//   clock      : clock; all state updates on its rising edge
//   rst        : synchronous, active-high reset
//   req_valid  : request present
//   req_ready  : request accepted this cycle when req_valid is high
//   req_we     : 1 = write, 0 = read
//   req_addr   : word address
//   req_wdata  : write data
//   rsp_valid  : read response available (FIFO not empty)
//   rsp_ready  : consumer takes the head response
//   rsp_rdata  : head response data
//   mem_en     : memory port enable
//   mem_we     : memory port write enable
//   mem_addr   : memory port address
//   mem_din    : memory port write data
//   mem_dout   : memory port read data, valid READ_LATENCY cycles after address
//   err        : sticky out-of-range flag
// -----------------------------------------------------------------------------
module mem_port_ctrl #(
  parameter int          READ_LATENCY = 2,
  parameter int          RSP_DEPTH    = 4,
  parameter logic [31:0] ADDR_LIMIT   = 32'h0000_4000
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        err
);

  localparam int          PW      = $clog2(RSP_DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(RSP_DEPTH);

  logic [READ_LATENCY-1:0] vld_q;
  logic [31:0]             fifo_mem [RSP_DEPTH];
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [CW-1:0]           count_q;
  logic [CW:0]             inflight;
  logic [CW:0]             used;
  logic                    fire;
  logic                    fire_rd;
  logic                    oob;
  logic                    push;
  logic                    pop;
  logic [31:0]             push_data;

  // Count the reads still in the latency pipe. They already own FIFO slots.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + (CW + 1)'(vld_q[i]);
    end
  end

  assign used      = {1'b0, count_q} + inflight;
  assign req_ready = !rst && (req_we || (used < DEPTH_V));
  assign fire      = req_valid && req_ready;
  assign fire_rd   = fire && !req_we;

  assign mem_en    = fire && !oob;
  assign mem_we    = fire && req_we && !oob;
  assign mem_addr  = req_addr;
  assign mem_din   = req_wdata;

  assign push      = vld_q[READ_LATENCY-1];
  assign rsp_valid = !rst && (count_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = fifo_mem[rd_ptr_q];

`ifdef MEM_PORT_BOUNDS_CHECK_EN
  // Out-of-range reads follow their own flag through the pipe. The poison
  // value then replaces the memory data at the same push slot, which keeps
  // the responses in order.
  logic [READ_LATENCY-1:0] oob_q;
  logic                    err_q;

  assign oob       = req_addr >= ADDR_LIMIT;
  assign push_data = oob_q[READ_LATENCY-1] ? 32'hDEAD_BEEF : mem_dout;
  assign err       = err_q && !rst;

  always_ff @(posedge clock) begin
    if (rst) begin
      oob_q <= '0;
      err_q <= 1'b0;
    end else begin
      oob_q[0] <= fire_rd && oob;
      for (int i = 1; i < READ_LATENCY; i++) begin
        oob_q[i] <= oob_q[i-1];
      end
      err_q <= err_q || (fire && oob);
    end
  end
`else
  assign oob       = 1'b0;
  assign push_data = mem_dout;
  assign err       = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q[0] <= fire_rd;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      // Pointers are PW bits wide and RSP_DEPTH is a power of two, so they
      // wrap on their own.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset. Only the pointers and the
  // count define which entries are live, and this keeps the array mappable
  // to RAM.
  always_ff @(posedge clock) begin
    if (push && !rst) fifo_mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_port_ctrl
//
// Directed bench for mem_port_ctrl with its default parameters
// (READ_LATENCY=2, RSP_DEPTH=4). A behavioural memory with a two-stage read
// pipe is attached to the memory port. Expected values are written by hand
// below. Inputs change 1 time unit after the rising edge. Outputs are sampled
// mid-cycle.
// -----------------------------------------------------------------------------
module tb_mem_port_ctrl;

  logic        clock = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_port_ctrl dut (
    .clock     (clock),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .err       (err)
  );

  // Memory model: the read data is valid two cycles after the address edge.
  logic [31:0] mem [65536];
  logic [31:0] pipe0;
  logic [31:0] pipe1;

  always @(posedge clock) begin
    if (mem_en && mem_we) mem[mem_addr[15:0]] <= mem_din;
    pipe0 <= mem[mem_addr[15:0]];
    pipe1 <= pipe0;
  end
  assign mem_dout = pipe1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    cyc();
    idle();
  endtask

  // Wait (bounded) for one response and check its data. The response is
  // popped because rsp_ready is held high.
  task automatic wait_rsp(input string tag, input logic [31:0] exp);
    logic found;
    found     = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      #4;
      if (rsp_valid) begin
        check(tag, rsp_rdata, exp);
        found = 1'b1;
      end
      cyc();
    end
    if (!found) check({tag, "_timeout"}, 32'(found), 32'd1);
  endtask

  initial begin
    int accepted;
    int issued;
    int got;
    int seen;

    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;
    #2;
    // Reset state, with a request offered.
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mem_en",    32'(mem_en),    32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_err",       32'(err),       32'd0);
    cyc();
    cyc();
    rst = 1'b0;

    // The first cycle after reset takes a write immediately.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h1234_5678;
    #4;
    check("first_ready", 32'(req_ready), 32'd1);
    check("wr_mem_en",   32'(mem_en),    32'd1);
    check("wr_mem_we",   32'(mem_we),    32'd1);
    check("wr_mem_din",  mem_din,        32'h1234_5678);
    cyc();

    // Read latency: a read fired in cycle T is visible in cycle T+3.
    req_we    = 1'b0;
    rsp_ready = 1'b1;
    #4;
    check("rd_mem_en",   32'(mem_en),    32'd1);
    check("rd_mem_we",   32'(mem_we),    32'd0);
    check("rd_mem_addr", mem_addr,       32'h10);
    cyc();
    req_valid = 1'b0;
    req_addr  = 32'h77;
    req_wdata = 32'h99;
    #4;
    check("idle_mem_en",   32'(mem_en),    32'd0);
    check("idle_mem_addr", mem_addr,       32'h77);
    check("idle_mem_din",  mem_din,        32'h99);
    check("lat_t1",        32'(rsp_valid), 32'd0);
    cyc();
    #4;
    check("lat_t2", 32'(rsp_valid), 32'd0);
    cyc();
    #4;
    check("lat_t3_valid", 32'(rsp_valid), 32'd1);
    check("lat_t3_data",  rsp_rdata,      32'h1234_5678);
    cyc();
    #4;
    check("lat_t4_empty", 32'(rsp_valid), 32'd0);
    cyc();

    // A write followed by a read of the same address returns the new data,
    // and produces exactly one response.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h1000;
    req_wdata = 32'hCAFE_0001;
    #4;
    check("raw_wr_en", 32'({mem_en, mem_we}), 32'b11);
    cyc();
    req_we = 1'b0;
    cyc();
    idle();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      #4;
      if (rsp_valid) begin
        seen++;
        check("raw_data", rsp_rdata, 32'hCAFE_0001);
      end
      cyc();
    end
    check("raw_count", 32'(seen), 32'd1);

    // Preload words 0x20..0x29 with 0xA000_0000 + index.
    for (int i = 0; i < 10; i++) do_write(32'h20 + 32'(i), 32'hA000_0000 + 32'(i));

    // Back-pressure: 6 reads offered back-to-back with no consumer.
    rsp_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h20 + 32'(accepted);
      #4;
      if (req_ready) accepted++;
      cyc();
    end
    check("bp_accepted", 32'(accepted), 32'd4);
    for (int i = 0; i < 3; i++) cyc();
    #4;
    check("bp_full_ready", 32'(req_ready), 32'd0);
    check("bp_full_valid", 32'(rsp_valid), 32'd1);
    cyc();

    // Drain while streaming the rest of the 10 reads. The pointers wrap.
    rsp_ready = 1'b1;
    issued    = accepted;
    got       = 0;
    for (int i = 0; i < 60 && got < 10; i++) begin
      req_valid = (issued < 10);
      req_addr  = 32'h20 + 32'(issued);
      #4;
      if (rsp_valid) begin
        check($sformatf("order_%0d", got), rsp_rdata, 32'hA000_0000 + 32'(got));
        got++;
      end
      if (req_valid && req_ready) issued++;
      cyc();
    end
    idle();
    check("drain_count", 32'(got), 32'd10);
    #4;
    check("drain_empty", 32'(rsp_valid), 32'd0);
    cyc();

    // Reset one cycle after two reads fire: nothing stale may appear.
    req_valid = 1'b1;
    req_addr  = 32'h20;
    cyc();
    req_addr = 32'h21;
    cyc();
    idle();
    rst = 1'b1;
    #4;
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    cyc();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      #4;
      if (rsp_valid) seen++;
      cyc();
    end
    check("midrst_stale", 32'(seen), 32'd0);
    req_valid = 1'b1;
    req_addr  = 32'h25;
    cyc();
    idle();
    wait_rsp("midrst_next", 32'hA000_0005);

    // Out-of-range access.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h4000;
    req_wdata = 32'h5555_AAAA;
    #4;
`ifdef MEM_PORT_BOUNDS_CHECK_EN
    check("oob_wr_en", 32'(mem_en), 32'd0);
`else
    check("oob_wr_en", 32'(mem_en), 32'd1);
`endif
    cyc();
    req_we = 1'b0;
    #4;
`ifdef MEM_PORT_BOUNDS_CHECK_EN
    check("oob_rd_en", 32'(mem_en), 32'd0);
    check("oob_err",   32'(err),    32'd1);
`else
    check("oob_rd_en", 32'(mem_en), 32'd1);
    check("oob_err",   32'(err),    32'd0);
`endif
    cyc();
    idle();
`ifdef MEM_PORT_BOUNDS_CHECK_EN
    wait_rsp("oob_rdata", 32'hDEAD_BEEF);
    check("oob_err_hold", 32'(err), 32'd1);
`else
    wait_rsp("oob_rdata", 32'h5555_AAAA);
    check("oob_err_hold", 32'(err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
